// File: rtl/bitpack_pkg.sv
// Shared types for the job sequencer: FSM states, page/count constants, queued descriptor.
// Descriptor address fields are sized for the widest supported ADDR_W; narrower builds zero-extend.
package bitpack_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_ISSUE,
        S_WAIT,
        S_DRAIN
    } state_t;

    localparam int PAGE_BYTES  = 4096;
    localparam int COUNT_W     = 16;
    localparam int DESC_ADDR_W = 64;

    typedef struct packed {
        logic [DESC_ADDR_W-1:0] src;
        logic [DESC_ADDR_W-1:0] dst;
        logic [31:0]            size;
    } desc_t;

endpackage

// File: rtl/bitpack_job_seq_if.sv
// Job-queue and mover-request bundle. master = sequencer side, slave = control/mover side.
// Perf counters exist only when BITPACK_JOB_SEQ_PERF_EN is defined.
interface bitpack_job_seq_if #(
    parameter int ADDR_W = 32
);
    import bitpack_pkg::*;

    logic [ADDR_W-1:0]  job_src;
    logic [ADDR_W-1:0]  job_dst;
    logic [31:0]        job_size;
    logic               job_push;
    logic               job_full;
    logic               job_done;
    logic               idle;
    logic [ADDR_W-1:0]  read_addr;
    logic [COUNT_W-1:0] read_count;
    logic               read_req;
    logic               read_busy;
    logic [ADDR_W-1:0]  write_addr;
    logic [COUNT_W-1:0] write_count;
    logic               write_req;
    logic               write_busy;
`ifdef BITPACK_JOB_SEQ_PERF_EN
    logic [31:0]        perf_cycles;
    logic [31:0]        perf_bursts;

    modport master (
        input  job_src, job_dst, job_size, job_push, read_busy, write_busy,
        output job_full, job_done, idle, read_addr, read_count, read_req,
               write_addr, write_count, write_req, perf_cycles, perf_bursts
    );
    modport slave (
        output job_src, job_dst, job_size, job_push, read_busy, write_busy,
        input  job_full, job_done, idle, read_addr, read_count, read_req,
               write_addr, write_count, write_req, perf_cycles, perf_bursts
    );
`else
    modport master (
        input  job_src, job_dst, job_size, job_push, read_busy, write_busy,
        output job_full, job_done, idle, read_addr, read_count, read_req,
               write_addr, write_count, write_req
    );
    modport slave (
        output job_src, job_dst, job_size, job_push, read_busy, write_busy,
        input  job_full, job_done, idle, read_addr, read_count, read_req,
               write_addr, write_count, write_req
    );
`endif

endinterface

// File: rtl/bitpack_desc_fifo.sv
// Register FIFO of job descriptors; pop data is combinational from the head entry.
// Push when full is dropped unless a pop happens in the same cycle.
module bitpack_desc_fifo
    import bitpack_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  desc_t push_dat,
    input  logic  pop,
    output desc_t pop_dat,
    output logic  full,
    output logic  empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    desc_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bitpack_job_seq.sv
// Splits queued copy jobs into MAX_BURST / 4 KiB-bounded mover requests; REQ registered, one cycle.
// Optional BITPACK_JOB_SEQ_PERF_EN adds saturating busy-cycle and burst counters.
module bitpack_job_seq
    import bitpack_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MAX_BURST   = 256,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    bitpack_job_seq_if.master bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam logic [ADDR_W-1:0] AMASK = ~(ADDR_W'(BYTES - 1));

    state_t             state;
    state_t             state_nxt;
    desc_t              push_dat;
    desc_t              pop_dat;
    logic               full;
    logic               empty;
    logic               pop;
    logic               done_set;
    logic               req_set;
    logic               chunk_load;
    logic               advance;
    logic               wait_cnt;
    logic [ADDR_W-1:0]  src_q;
    logic [ADDR_W-1:0]  dst_q;
    logic [31:0]        rem_q;
    logic [COUNT_W-1:0] chunk_q;
    logic [COUNT_W-1:0] chunk_nxt;
    logic [ADDR_W-1:0]  step;
    logic [12:0]        src_room;
    logic [12:0]        dst_room;
    logic [31:0]        lim;
    logic               done_q;
    logic               req_q;
    logic [ADDR_W-1:0]  raddr_q;
    logic [ADDR_W-1:0]  waddr_q;
    logic [COUNT_W-1:0] count_q;
    logic               busy_any;
    logic               unused_desc;

    assign push_dat.src  = DESC_ADDR_W'(bus.job_src);
    assign push_dat.dst  = DESC_ADDR_W'(bus.job_dst);
    assign push_dat.size = bus.job_size;
    // Upper descriptor bits are zero-extension only.
    assign unused_desc   = ^{pop_dat.src, pop_dat.dst};

    bitpack_desc_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .push     (bus.job_push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (pop_dat),
        .full     (full),
        .empty    (empty)
    );

    assign busy_any = bus.read_busy || bus.write_busy;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        done_set   = 1'b0;
        req_set    = 1'b0;
        chunk_load = 1'b0;
        advance    = 1'b0;
        unique case (state)
            S_IDLE: if (!empty) begin
                pop       = 1'b1;
                state_nxt = S_CALC;
            end
            S_CALC: if (rem_q == '0) begin
                done_set  = 1'b1;
                state_nxt = S_IDLE;
            end else begin
                chunk_load = 1'b1;
                state_nxt  = S_ISSUE;
            end
            S_ISSUE: if (!busy_any) begin
                req_set   = 1'b1;
                state_nxt = S_WAIT;
            end
            // Second WAIT cycle falls through even if the mover never raised BUSY.
            S_WAIT: if (busy_any || wait_cnt) state_nxt = S_DRAIN;
            S_DRAIN: if (!busy_any) begin
                advance   = 1'b1;
                state_nxt = S_CALC;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        src_room = 13'(PAGE_BYTES) - {1'b0, src_q[11:0]};
        dst_room = 13'(PAGE_BYTES) - {1'b0, dst_q[11:0]};
        lim      = rem_q;
        if (lim > 32'(MAX_BURST))        lim = 32'(MAX_BURST);
        if (lim > 32'(src_room >> BSH))  lim = 32'(src_room >> BSH);
        if (lim > 32'(dst_room >> BSH))  lim = 32'(dst_room >> BSH);
        chunk_nxt = lim[COUNT_W-1:0];
        step      = ADDR_W'(chunk_q) << BSH;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            src_q    <= '0;
            dst_q    <= '0;
            rem_q    <= '0;
            chunk_q  <= '0;
            wait_cnt <= 1'b0;
            done_q   <= 1'b0;
            req_q    <= 1'b0;
            raddr_q  <= '0;
            waddr_q  <= '0;
            count_q  <= '0;
        end else begin
            wait_cnt <= (state == S_WAIT);
            done_q   <= done_set;
            req_q    <= req_set;
            if (pop) begin
                src_q <= pop_dat.src[ADDR_W-1:0] & AMASK;
                dst_q <= pop_dat.dst[ADDR_W-1:0] & AMASK;
                rem_q <= pop_dat.size >> BSH;
            end
            if (chunk_load) chunk_q <= chunk_nxt;
            if (req_set) begin
                raddr_q <= src_q;
                waddr_q <= dst_q;
                count_q <= chunk_q;
            end
            if (advance) begin
                src_q <= src_q + step;
                dst_q <= dst_q + step;
                rem_q <= rem_q - 32'(chunk_q);
            end
        end
    end

    assign bus.job_full    = full;
    assign bus.job_done    = done_q;
    assign bus.idle        = empty && (state == S_IDLE) && !busy_any;
    assign bus.read_req    = req_q;
    assign bus.write_req   = req_q;
    assign bus.read_addr   = raddr_q;
    assign bus.write_addr  = waddr_q;
    assign bus.read_count  = count_q;
    assign bus.write_count = count_q;

`ifdef BITPACK_JOB_SEQ_PERF_EN
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_bursts_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            perf_cycles_q <= '0;
            perf_bursts_q <= '0;
        end else begin
            if (state != S_IDLE && perf_cycles_q != '1) perf_cycles_q <= perf_cycles_q + 1'b1;
            if (req_q && perf_bursts_q != '1)           perf_bursts_q <= perf_bursts_q + 1'b1;
        end
    end

    assign bus.perf_cycles = perf_cycles_q;
    assign bus.perf_bursts = perf_bursts_q;
`endif

endmodule
